// File: rtl/frame_stream_ctrl_if.sv
// Avalon-ST pixel stream from the scan-out sequencer to the video scaler sink.
interface frame_stream_ctrl_if #(
  parameter int unsigned DATA_W = 30
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/frame_stream_ctrl.sv
// Raster-order frame-buffer reader: issues addresses under a 2-credit rule, absorbs the
// 1-clk read latency in a 2-entry output FIFO and tags pixels with SOP/EOP.
module frame_stream_ctrl #(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 30,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic [SEL_W-1:0]      menu_choice_in,
  output logic [SEL_W-1:0]      menu_choice_out,
  output logic [ADDR_W-1:0]     rdaddress,
  input  logic [DATA_W-1:0]     rddata,
  frame_stream_ctrl_if.master   out,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_count
);

  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic                infl_q, infl_sop_q, infl_eop_q;
  logic [DATA_W-1:0]   head_data_q, skid_data_q;
  logic                head_vld_q, head_sop_q, head_eop_q;
  logic                skid_vld_q, skid_sop_q, skid_eop_q;
  logic                flush_c, pop_c, issue_c, push_c;
  logic                at_sop_c, at_eop_c;
  logic [2:0]          credit_c;

  assign out.data  = head_data_q;
  assign out.valid = head_vld_q;
  assign out.sop   = head_sop_q;
  assign out.eop   = head_eop_q;

  assign at_sop_c = (col_q == '0) && (row_q == '0);
  assign at_eop_c = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign push_c   = infl_q;

  // Outstanding reads (FIFO occupancy + in-flight) may never exceed 2 after this cycle.
  always_comb begin
    state_d  = state_q;
    flush_c  = 1'b0;
    pop_c    = 1'b0;
    issue_c  = 1'b0;
    credit_c = 3'(head_vld_q) + 3'(skid_vld_q) + 3'(infl_q);
    case (state_q)
      RUN: begin
        if (restart) begin
          flush_c = 1'b1;
          state_d = FLUSH;
        end else begin
          pop_c   = head_vld_q & out.ready;
          issue_c = (credit_c - 3'(pop_c)) < 3'd2;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (!restart) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // Address/position counters, read tracking and frame bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdaddress       <= '0;
      col_q           <= '0;
      row_q           <= '0;
      infl_q          <= 1'b0;
      infl_sop_q      <= 1'b0;
      infl_eop_q      <= 1'b0;
      menu_choice_out <= '0;
      frame_done      <= 1'b0;
      frame_count     <= '0;
    end else if (flush_c) begin
      rdaddress  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      infl_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop_c & head_eop_q;
      if (pop_c && head_eop_q) frame_count <= frame_count + CNT_W'(1);
      infl_q <= issue_c;
      if (issue_c) begin
        infl_sop_q <= at_sop_c;
        infl_eop_q <= at_eop_c;
        if (rdaddress == '0) menu_choice_out <= menu_choice_in;
        rdaddress <= at_eop_c ? '0 : rdaddress + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Two-entry FIFO as head + skid registers; head only moves on pop so it holds under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      head_sop_q  <= 1'b0;
      head_eop_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sop_q  <= 1'b0;
      skid_eop_q  <= 1'b0;
    end else if (flush_c) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      case ({pop_c, push_c})
        2'b11: begin
          if (skid_vld_q) begin
            head_data_q <= skid_data_q;
            head_sop_q  <= skid_sop_q;
            head_eop_q  <= skid_eop_q;
            skid_data_q <= rddata;
            skid_sop_q  <= infl_sop_q;
            skid_eop_q  <= infl_eop_q;
          end else begin
            head_data_q <= rddata;
            head_sop_q  <= infl_sop_q;
            head_eop_q  <= infl_eop_q;
          end
        end
        2'b10: begin
          if (skid_vld_q) begin
            head_data_q <= skid_data_q;
            head_sop_q  <= skid_sop_q;
            head_eop_q  <= skid_eop_q;
            skid_vld_q  <= 1'b0;
          end else begin
            head_vld_q <= 1'b0;
          end
        end
        2'b01: begin
          if (!head_vld_q) begin
            head_vld_q  <= 1'b1;
            head_data_q <= rddata;
            head_sop_q  <= infl_sop_q;
            head_eop_q  <= infl_eop_q;
          end else begin
            skid_vld_q  <= 1'b1;
            skid_data_q <= rddata;
            skid_sop_q  <= infl_sop_q;
            skid_eop_q  <= infl_eop_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Randomized bench for frame_stream_ctrl on a 4x3 frame with a 2-bit frame counter;
// a background scoreboard tracks the expected raster stream.
module tb_frame_stream_ctrl;
  localparam int unsigned H = 4, V = 3, NPIX = 12;
  localparam int unsigned AW = 17, DW = 30, SW = 3, CW = 2;

  logic          clk = 1'b0;
  logic          reset_n, restart;
  logic [SW-1:0] menu_in, menu_out;
  logic [AW-1:0] rdaddress, ram_q;
  logic [DW-1:0] rddata;
  logic          frame_done;
  logic [CW-1:0] frame_count;

  frame_stream_ctrl_if #(.DATA_W(DW)) st ();

  frame_stream_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .menu_choice_in(menu_in), .menu_choice_out(menu_out),
    .rdaddress(rdaddress), .rddata(rddata), .out(st),
    .frame_done(frame_done), .frame_count(frame_count));

  always #20 clk = ~clk;

  // Frame buffer with 1-clk read latency; the filter stage tags each pixel with its selection.
  always @(posedge clk) ram_q <= rdaddress;
  assign rddata = {10'd0, menu_out, ram_q};

  function automatic logic [DW-1:0] pix_word(input int pix, input logic [SW-1:0] sel);
    return {10'd0, sel, AW'(pix)};
  endfunction

  int            n_checks = 0, n_pass = 0;
  int            exp_pix, exp_fc, acc_beats;
  bit            exp_done, sb_en, prev_stall;
  logic [SW-1:0] frame_sel;
  logic [DW-1:0] prev_data;
  logic          prev_sop, prev_eop;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pix(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_pix == target) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic model_clear();
    exp_pix = 0; exp_fc = 0; exp_done = 1'b0; prev_stall = 1'b0; frame_sel = '0;
  endtask

  task automatic test_reset();
    sb_en = 1'b0; reset_n = 1'b0; restart = 1'b0; menu_in = '0; st.ready = 1'b0;
    model_clear();
    acc_beats = 0;
    step(); step();
    n_checks++; if (rdaddress !== '0) $display("FAIL reset_rdaddress: got %0h want 0", rdaddress); else n_pass++;
    n_checks++; if (st.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", st.valid); else n_pass++;
    n_checks++; if (st.sop !== 1'b0 || st.eop !== 1'b0) $display("FAIL reset_sop_eop: got %b%b want 00", st.sop, st.eop); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    n_checks++; if (frame_count !== '0) $display("FAIL reset_frame_count: got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (menu_out !== '0) $display("FAIL reset_menu: got %0d want 0", menu_out); else n_pass++;
    reset_n = 1'b1; st.ready = 1'b1; sb_en = 1'b1;
    step();
    n_checks++; if (st.valid !== 1'b0) $display("FAIL latency_clk1_valid: got %b want 0", st.valid); else n_pass++;
    n_checks++; if (rdaddress !== AW'(1)) $display("FAIL latency_clk1_addr: got %0d want 1", rdaddress); else n_pass++;
    step();
    n_checks++; if (st.valid !== 1'b1) $display("FAIL latency_clk2_valid: got %b want 1", st.valid); else n_pass++;
    n_checks++; if (st.sop !== 1'b1 || st.data !== pix_word(0, 0)) $display("FAIL first_beat: got sop=%b data=%0h want sop=1 data=%0h", st.sop, st.data, pix_word(0, 0)); else n_pass++;
  endtask

  task automatic test_stream_full();
    for (int i = 0; i < int'(NPIX); i++) begin
      n_checks++; if (st.valid !== 1'b1) $display("FAIL no_bubble_%0d: got valid=%b want 1", i, st.valid); else n_pass++;
      n_checks++; if (rdaddress !== AW'((2 + i) % NPIX)) $display("FAIL addr_seq_%0d: got %0d want %0d", i, rdaddress, (2 + i) % NPIX); else n_pass++;
      step();
    end
    n_checks++; if (frame_done !== 1'b1) $display("FAIL frame_done_pulse: got %b want 1", frame_done); else n_pass++;
    n_checks++; if (frame_count !== CW'(1)) $display("FAIL frame_count_one: got %0d want 1", frame_count); else n_pass++;
    step();
    n_checks++; if (frame_done !== 1'b0) $display("FAIL frame_done_single: got %b want 0", frame_done); else n_pass++;
  endtask

  task automatic test_stall();
    int start;
    start = acc_beats;
    for (int i = 0; i < 40; i++) begin
      st.ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    for (int i = 0; i < 120; i++) begin
      st.ready = ($urandom_range(0, 2) != 0);
      step();
    end
    st.ready = 1'b1;
    n_checks++; if (acc_beats - start < 40) $display("FAIL stall_progress: got %0d beats want >= 40", acc_beats - start); else n_pass++;
  endtask

  task automatic test_menu();
    bit ok;
    wait_pix(5, 200, ok);
    n_checks++; if (!ok) $display("FAIL menu_wait_beat5: got timeout want beat 5"); else n_pass++;
    menu_in = 3'd3;
    while (exp_pix >= 5 && exp_pix <= 9) begin
      st.ready = ($urandom_range(0, 3) != 0);
      n_checks++; if (menu_out !== '0) $display("FAIL menu_hold_pix%0d: got %0d want 0", exp_pix, menu_out); else n_pass++;
      step();
    end
    st.ready = 1'b1;
    wait_pix(1, 200, ok);
    n_checks++; if (!ok) $display("FAIL menu_wait_next_frame: got timeout want pixel 0 accepted"); else n_pass++;
    n_checks++; if (menu_out !== 3'd3) $display("FAIL menu_new_frame: got %0d want 3", menu_out); else n_pass++;
  endtask

  task automatic test_restart();
    bit ok;
    int saved_fc;
    st.ready = 1'b1;
    wait_pix(6, 200, ok);
    n_checks++; if (!ok) $display("FAIL restart_wait: got timeout want beat 6"); else n_pass++;
    saved_fc = exp_fc;
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++; if (st.valid !== 1'b0) $display("FAIL restart_flush_valid: got %b want 0", st.valid); else n_pass++;
    n_checks++; if (rdaddress !== '0) $display("FAIL restart_addr: got %0d want 0", rdaddress); else n_pass++;
    wait_pix(1, 50, ok);
    n_checks++; if (!ok) $display("FAIL restart_resume: got timeout want pixel 0"); else n_pass++;
    n_checks++; if (frame_count !== CW'(saved_fc)) $display("FAIL restart_fc: got %0d want %0d", frame_count, saved_fc); else n_pass++;
    wait_pix(3, 50, ok);
    restart = 1'b1;
    step();
    n_checks++; if (st.valid !== 1'b0) $display("FAIL restart2_valid_a: got %b want 0", st.valid); else n_pass++;
    step();
    restart = 1'b0;
    n_checks++; if (st.valid !== 1'b0) $display("FAIL restart2_valid_b: got %b want 0", st.valid); else n_pass++;
    wait_pix(1, 50, ok);
    n_checks++; if (!ok) $display("FAIL restart2_resume: got timeout want pixel 0"); else n_pass++;
    n_checks++; if (frame_count !== CW'(saved_fc)) $display("FAIL restart2_fc: got %0d want %0d", frame_count, saved_fc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_pix(7, 50, ok);
    st.ready = 1'b0;
    step(); step(); step();
    n_checks++; if (st.valid !== 1'b1) $display("FAIL pre_reset_stalled: got %b want 1", st.valid); else n_pass++;
    sb_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (st.valid !== 1'b0 || st.sop !== 1'b0 || st.eop !== 1'b0) $display("FAIL async_reset_stream: got v%b s%b e%b want 000", st.valid, st.sop, st.eop); else n_pass++;
    n_checks++; if (rdaddress !== '0 || frame_done !== 1'b0) $display("FAIL async_reset_addr: got %0d/%b want 0/0", rdaddress, frame_done); else n_pass++;
    n_checks++; if (frame_count !== '0 || menu_out !== '0) $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", frame_count, menu_out); else n_pass++;
    step();
    reset_n = 1'b1;
    model_clear();
    st.ready = 1'b1;
    sb_en = 1'b1;
    wait_pix(1, 50, ok);
    n_checks++; if (!ok) $display("FAIL reset_resume: got timeout want pixel 0"); else n_pass++;
    n_checks++; if (frame_count !== '0) $display("FAIL reset_resume_fc: got %0d want 0", frame_count); else n_pass++;
  endtask

  task automatic test_wrap();
    int k;
    k = 0;
    for (int i = 0; i < 600 && k < 5; i++) begin
      st.ready = ($urandom_range(0, 4) != 0);
      step();
      if (frame_done === 1'b1) begin
        n_checks++; if (frame_count !== CW'((k + 1) % 4)) $display("FAIL wrap_seq_%0d: got %0d want %0d", k, frame_count, (k + 1) % 4); else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 5) $display("FAIL wrap_frames: got %0d want 5", k); else n_pass++;
  endtask

  initial begin
    sb_en = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (sb_en) begin
          int lead;
          n_checks++; if (frame_done !== exp_done) $display("FAIL sb_frame_done: got %b want %b", frame_done, exp_done); else n_pass++;
          n_checks++; if (frame_count !== CW'(exp_fc)) $display("FAIL sb_frame_count: got %0d want %0d", frame_count, exp_fc); else n_pass++;
          lead = (int'(rdaddress) + int'(NPIX) - exp_pix) % int'(NPIX);
          n_checks++; if (lead > 2) $display("FAIL sb_addr_lead: got addr %0d with pixel %0d pending want lead <= 2", rdaddress, exp_pix); else n_pass++;
          if (prev_stall) begin
            n_checks++;
            if (st.valid !== 1'b1 || st.data !== prev_data || st.sop !== prev_sop || st.eop !== prev_eop)
              $display("FAIL sb_stall_hold: got v%b %0h want v1 %0h", st.valid, st.data, prev_data);
            else n_pass++;
          end
          prev_stall = 1'b0;
          exp_done = 1'b0;
          if (restart) begin
            exp_pix = 0;
          end else if (st.valid === 1'b1 && st.ready === 1'b1) begin
            if (exp_pix == 0) frame_sel = menu_in;
            n_checks++;
            if (st.data !== pix_word(exp_pix, frame_sel) || st.sop !== (exp_pix == 0) || st.eop !== (exp_pix == int'(NPIX) - 1))
              $display("FAIL sb_beat_%0d: got %0h sop%b eop%b want %0h sop%b eop%b", exp_pix, st.data, st.sop, st.eop,
                       pix_word(exp_pix, frame_sel), exp_pix == 0, exp_pix == int'(NPIX) - 1);
            else n_pass++;
            if (exp_pix == int'(NPIX) - 1) begin
              exp_done = 1'b1;
              exp_fc = (exp_fc + 1) % (1 << CW);
            end
            exp_pix = (exp_pix + 1) % int'(NPIX);
            acc_beats++;
          end else if (st.valid === 1'b1) begin
            prev_stall = 1'b1;
            prev_data = st.data;
            prev_sop = st.sop;
            prev_eop = st.eop;
          end
        end
      end
    join_none
    test_reset();
    test_stream_full();
    test_stall();
    test_menu();
    test_restart();
    test_reset_mid();
    test_wrap();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/frame_stream_ctrl.md
Name: frame_stream_ctrl

Overview:
Sequences the VGA scan-out datapath. It generates frame-buffer read addresses in raster order and absorbs the 1-cycle buffer read latency. Each pixel is tagged with start/end-of-packet, and the resulting Avalon-ST stream is presented to the video scaler sink with real valid/ready backpressure. It also latches the filter selection at frame boundaries so a filter change never tears a frame. It runs in the clk_25_vga domain, between frame_buffer/pixel_filters and vga_demo.

Parameters:
H_RES, 320, active pixels per line
V_RES, 240, lines per frame
ADDR_W, 17, frame-buffer address width; H_RES*V_RES must be <= 2**ADDR_W
DATA_W, 30, pixel width (filtered RGB 10:10:10)
SEL_W, 3, filter-selection width
CNT_W, 16, frame counter width

Ports:
clk  in  1  pixel clock (clk_25_vga)
reset_n  in  1  asynchronous, active-low reset
restart  in  1  synchronous pulse; abort current frame, restart at pixel 0
menu_choice_in  in  SEL_W  live filter selection from menu
menu_choice_out  out  SEL_W  frame-stable selection driven to pixel_filters
rdaddress  out  ADDR_W  frame-buffer read address
rddata  in  DATA_W  filtered pixel, valid exactly 1 clk after rdaddress
out_data  out  DATA_W  stream pixel
out_valid  out  1  stream valid
out_ready  in  1  stream ready from scaler sink
out_sop  out  1  high with pixel (0,0)
out_eop  out  1  high with pixel (H_RES-1,V_RES-1)
frame_done  out  1  1-clk pulse when the EOP beat is accepted
frame_count  out  CNT_W  completed frames, wraps

Behaviour:
- Reset (reset_n=0, async): rdaddress=0, out_valid=0, out_sop=0, out_eop=0, frame_done=0, frame_count=0, menu_choice_out=0. Internal state: FIFO empty, no read in flight, state=RUN.
- Address generation:
  - Linear counter, incremented by 1 per issued read; no multiplier.
  - Wraps from H_RES*V_RES-1 to 0.
  - col/row counters track position for SOP/EOP tagging.
- Read issue:
  - A read issues in cycle t when (fifo_count + inflight - pop_t) < 2, where pop_t = out_valid & out_ready.
  - The datum for that read is written to a 2-entry output FIFO at t+1, together with its sop/eop tags.
- Output:
  - out_valid = FIFO non-empty. out_data/out_sop/out_eop are driven from the FIFO head.
  - Head is held stable while out_valid & !out_ready.
  - Beat accepted when out_valid & out_ready.
  - Sustained throughput of 1 pixel/clk when out_ready stays high.
  - Latency from reset release to first out_valid: 2 clk.
- Filter selection:
  - menu_choice_out <= menu_choice_in in the cycle address 0 is issued; held otherwise.
  - Pixel 0 data (returned the next cycle) is therefore filtered with the new selection; the prior frame's last pixel keeps the old selection.
- States: RUN, FLUSH.
  - RUN: normal operation.
  - restart=1 in RUN -> FLUSH. Issuing stops; FIFO and in-flight read are discarded (out_valid=0 from the next clk); address and col/row reset to 0.
  - FLUSH lasts exactly 1 clk -> RUN. The first beat afterwards is pixel 0 with out_sop=1.
  - restart during FLUSH: stays FLUSH one more clk.
  - A truncated frame emits no EOP; frame_done and frame_count are not affected.
- frame_done/frame_count:
  - Asserted/incremented only on acceptance of the EOP beat.
  - frame_count wraps from 2**CNT_W-1 to 0.
- Simultaneous events:
  - If pop and push occur in the same cycle with the FIFO full, fifo_count is unchanged; no overflow is possible by the credit rule.
  - restart has priority over pop/issue.
- reset_n asserted mid-frame clears everything immediately, regardless of handshake state.
- H_RES=1 or V_RES=1 is legal: SOP and EOP may coincide on one beat.

Test Plan:
- Reset, then H_RES=4, V_RES=3, out_ready=1 -> first out_valid at clk 2 with rdaddress sequence 0..11 then 0. out_sop on beat 0; out_eop on beat 11. frame_done pulses once; frame_count=1 after 12 accepted beats with no bubbles.
- Same config, out_ready toggling 1,0,0,1 pattern with rddata=address -> out_data sequence exactly 0..11. No duplicates or drops; out_data stable while stalled; rdaddress never more than 2 ahead of the accepted beat.
- menu_choice_in changes 0->3 at beat 5 -> menu_choice_out stays 0 until address 0 of the next frame is issued, then becomes 3.
- restart asserted at beat 6 -> out_valid=0 for the following clk. The next beat has data=0 with out_sop=1. No EOP is emitted for the aborted frame and frame_count is unchanged.
- reset_n pulsed low for 1 clk mid-frame while stalled -> all outputs return to reset values asynchronously; after release the stream resumes at pixel 0 with frame_count=0.
- CNT_W=2, run 5 full frames -> frame_count sequence 1,2,3,0,1.
